// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the handshaked data memory.
//   funct3 encodings for RISC-V loads/stores, FSM states and byte-lane helpers.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] SD = 3'b011;

    typedef enum logic {IDLE, RESP} state_e;

    localparam int LANES_32 = 4;
    localparam int LANES_64 = 8;

    function automatic int lane_cnt(input int dw);
        return dw / 8;
    endfunction

    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one memory word.
//   Inputs : we_i (store), funct3_i, off_i (byte offset in word), wdata_i
//            (right-justified store data), word_i (current memory word).
//   Outputs: be_o (byte enables), wdata_o (store data moved to its lanes),
//            rdata_o (extracted and extended load data), illegal_o (bad
//            funct3), misalign_o (unaligned access; only raised when
//            DMEM_MISALIGN_TRAP_EN is defined, otherwise accesses align down).
module dmem_lane_align import dmem_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          we_i,
    input  logic [2:0]                    funct3_i,
    input  logic [lane_bits(DATA_WIDTH)-1:0] off_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [DATA_WIDTH-1:0]         word_i,
    output logic [lane_cnt(DATA_WIDTH)-1:0] be_o,
    output logic [DATA_WIDTH-1:0]         wdata_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          illegal_o,
    output logic                          misalign_o
);
    localparam int NB = lane_cnt(DATA_WIDTH);

    int nbytes;
    int base;
    logic [DATA_WIDTH-1:0] raw;

    always_comb begin
        nbytes = 1 << funct3_i[1:0];
        base   = int'(off_i) & ~(nbytes - 1);
        for (int i = 0; i < NB; i++)
            be_o[i] = (i >= base) && (i < base + nbytes);
        wdata_o = wdata_i << (8 * base);
        raw     = word_i >> (8 * base);
        rdata_o = funct3_i == LB  ? DATA_WIDTH'($signed(raw[7:0]))  :
                  funct3_i == LH  ? DATA_WIDTH'($signed(raw[15:0])) :
                  funct3_i == LW  ? DATA_WIDTH'($signed(raw[31:0])) :
                  funct3_i == LBU ? DATA_WIDTH'(raw[7:0])           :
                  funct3_i == LHU ? DATA_WIDTH'(raw[15:0])          :
                  funct3_i == LWU ? DATA_WIDTH'(raw[31:0])          : raw;
        // 011/110 need a 64-bit word; stores have no unsigned forms.
        illegal_o = (funct3_i == 3'b111) || (we_i && funct3_i[2]) ||
                    (DATA_WIDTH == 32 && (funct3_i == LD || funct3_i == LWU));
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign_o = (int'(off_i) & (nbytes - 1)) != 0;
`else
        misalign_o = 1'b0;
`endif
    end

endmodule

// File: rtl/data_mem_hs.sv
// data_mem_hs: valid/ready data memory with RISC-V load/store sizing.
//   Request : req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata.
//   Response: rsp_valid/rsp_ready, rsp_rdata (0 for stores/faults), rsp_err.
//   Status  : err_cnt, saturating count of faulted accesses.
//   One outstanding response; latency of one cycle; async active-low reset.
//   Optional: DMEM_MISALIGN_TRAP_EN turns misaligned accesses into faults.
module data_mem_hs import dmem_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [7:0]            err_cnt
);
    localparam int NB  = lane_cnt(DATA_WIDTH);
    localparam int OW  = lane_bits(DATA_WIDTH);
    localparam int MWB = $clog2(MEM_WORDS);
    localparam int IW  = ADDR_WIDTH - OW;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [IW-1:0]         idx;
    logic [MWB-1:0]        widx;
    logic                  in_range, accept, fault, wr_en, illegal, misalign;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata_sh, ld_data;

    assign idx       = req_addr[ADDR_WIDTH-1:OW];
    assign widx      = idx[MWB-1:0];
    // Any index bit above the depth means out of range; no wrap-around.
    assign in_range  = (idx >> MWB) == '0;
    assign req_ready = (state_q == IDLE) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign fault     = illegal || misalign || !in_range;
    // Gate on rst_n so a store coinciding with reset assertion is dropped.
    assign wr_en     = accept && req_we && !fault && rst_n;

    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign err_cnt   = err_cnt_q;

    dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .we_i       (req_we),
        .funct3_i   (req_funct3),
        .off_i      (req_addr[OW-1:0]),
        .wdata_i    (req_wdata),
        .word_i     (mem[widx]),
        .be_o       (be),
        .wdata_o    (wdata_sh),
        .rdata_o    (ld_data),
        .illegal_o  (illegal),
        .misalign_o (misalign)
    );

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (state_q == RESP && rsp_ready) state_d = IDLE;
        if (accept) begin
            state_d = RESP;
            rdata_d = (fault || req_we) ? '0 : ld_data;
            err_d   = fault;
            if (fault && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs: scoreboard bench for data_mem_hs (default 32-bit build).
module tb_data_mem_hs;
    import dmem_pkg::*;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  err_cnt;

    typedef struct {logic [31:0] d; logic e;} exp_t;
    exp_t sb[$];
    exp_t mon_x;
    int   n_cmp = 0, n_bad = 0, waits = 0, exp_cnt = 0;

    data_mem_hs dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        exp_t x;
        x.d = ed;
        x.e = ee;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        sb.push_back(x);
        if (ee && exp_cnt < 255) exp_cnt++;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 50) check("accept_timeout", 64'(waits), 0);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
                mon_x = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_x.d);
                check("rsp_err", rsp_err, mon_x.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        rsp_ready = 1;
        #1 check("rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        send(1, SW, 32'h10, 32'hDEADBEEF, 0, 0);
        send(0, LW, 32'h10, 0, 32'hDEADBEEF, 0);
        send(1, SB, 32'h13, 32'h80, 0, 0);
        send(0, LB, 32'h13, 0, 32'hFFFFFF80, 0);
        send(0, LBU, 32'h13, 0, 32'h00000080, 0);
        send(0, LHU, 32'h12, 0, 32'h000080AD, 0);
        send(0, LH, 32'h12, 0, 32'hFFFF80AD, 0);
        send(1, SW, 32'h14, 32'h11223344, 0, 0);
        send(1, SH, 32'h16, 32'hFFFFABCD, 0, 0);
        send(0, LW, 32'h14, 0, 32'hABCD3344, 0);
        send(0, LB, 32'h15, 0, 32'h00000033, 0);
        send(0, LHU, 32'h14, 0, 32'h00003344, 0);
        send(1, SW, 32'h0, 32'hCAFEF00D, 0, 0);
        send(1, SW, 32'h3FC, 32'h5A5A5A5A, 0, 0);
        send(0, LW, 32'h3FC, 0, 32'h5A5A5A5A, 0);
        send(1, SW, 32'h400, 32'h12345678, 0, 1);
        send(0, LW, 32'h0, 0, 32'hCAFEF00D, 0);
        drain();
        check("err_cnt_oor", err_cnt, 64'(exp_cnt));

        send(0, LD, 32'h0, 0, 0, 1);
        send(0, 3'b111, 32'h0, 0, 0, 1);
        send(1, 3'b100, 32'h0, 32'hFFFFFFFF, 0, 1);
        send(0, LW, 32'h0, 0, 32'hCAFEF00D, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        send(0, LW, 32'h11, 0, 0, 1);
        send(0, LH, 32'h13, 0, 0, 1);
        send(1, SW, 32'h01, 32'h0, 0, 1);
`else
        send(0, LW, 32'h11, 0, 32'h80ADBEEF, 0);
        send(0, LH, 32'h13, 0, 32'hFFFF80AD, 0);
        send(1, SW, 32'h01, 32'h0BADF00D, 0, 0);
        send(0, LW, 32'h0, 0, 32'h0BADF00D, 0);
        send(1, SW, 32'h0, 32'hCAFEF00D, 0, 0);
`endif
        send(0, LW, 32'h0, 0, 32'hCAFEF00D, 0);
        drain();
        check("err_cnt_illegal", err_cnt, 64'(exp_cnt));

        rsp_ready = 0;
        send(0, LW, 32'h10, 0, 32'h80ADBEEF, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'h80ADBEEF);
            check("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        send(0, LW, 32'h14, 0, 32'hABCD3344, 0);
        check("bp_back_to_back_waits", 64'(waits), 0);
        drain();

        for (int i = 0; i < 260; i++) send(0, 3'b111, 32'h0, 0, 0, 1);
        drain();
        check("err_cnt_saturate", err_cnt, 255);

        rsp_ready = 0;
        send(0, LW, 32'h10, 0, 32'h80ADBEEF, 0);
        @(negedge clk);
        check("mid_rsp_valid_before", rsp_valid, 1);
        rst_n = 0;
        sb.delete();
        exp_cnt = 0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        rsp_ready = 1;
        #1 check("mid_rst_req_ready", req_ready, 1);
        @(posedge clk); #1;
        send(0, LW, 32'h10, 0, 32'h80ADBEEF, 0);
        send(0, LW, 32'h14, 0, 32'hABCD3344, 0);
        drain();
        check("err_cnt_final", err_cnt, 64'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
